// File: rtl/raymarch_view_core_if.sv
// Marcher query bus: ray vectors and start pulse out, hit/shade result back.
interface raymarch_view_core_if;
    logic               march_start;
    logic signed [15:0] origin_x, origin_y, origin_z;
    logic signed [15:0] dir_x, dir_y, dir_z;
    logic signed [15:0] light_x, light_y, light_z;
    logic               march_done;
    logic               march_hit;
    logic signed [15:0] march_intensity;

    modport master (
        output march_start, origin_x, origin_y, origin_z, dir_x, dir_y, dir_z,
               light_x, light_y, light_z,
        input  march_done, march_hit, march_intensity
    );
    modport slave (
        input  march_start, origin_x, origin_y, origin_z, dir_x, dir_y, dir_z,
               light_x, light_y, light_z,
        output march_done, march_hit, march_intensity
    );
endinterface

// File: rtl/raymarch_view_core.sv
// Orbiting camera + per-pixel ray generator feeding a variable-latency marcher.
// Optional DITHER_PHASE_EN: per-line/frame query phase for temporal anti-aliasing.
module raymarch_view_core #(
    parameter int H_VISIBLE   = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int PIX_LOG2    = 3,
    parameter int ROT_SHIFT_A = 5,
    parameter int ROT_SHIFT_B = 6,
    parameter int LUMA_W      = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [10:0]            h_count,
    input  logic [9:0]             v_count,
    input  logic                   frame,
    input  logic                   pause,
    input  logic [1:0]             speed,
    raymarch_view_core_if.master   mq,
    output logic                   obj_visible,
    output logic [LUMA_W-1:0]      obj_luma,
    output logic                   overrun
);
    localparam logic signed [15:0] INIT_A   = 16'sh2d3f;
    localparam logic signed [15:0] INIT_ONE = 16'sh4000;
    localparam logic [10:0] H_TRIG = 11'(H_TOTAL - 15);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_VISIBLE - 8);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

    typedef enum logic {IDLE, ROT} state_t;
    state_t state, state_nx;
    logic [1:0] step_cnt;

    logic signed [15:0] cos_a, sin_a, cos_b, sin_b;
    logic signed [15:0] sin_ab, cos_ab, sin_a_cos_b, cos_a_cos_b;

    function automatic logic signed [21:0] sx(input logic signed [15:0] v);
        return {{6{v[15]}}, v};
    endfunction

    // One Minsky step: a-axis on all three pairs, then b-axis coupling.
    logic signed [15:0] ca_n, sa_n, cab_a, sab_a, cacb_a, sacb_a;
    logic signed [15:0] cb_n, sb_n, cacb_n, cab_n, sacb_n, sab_n;
    logic wrap;
    assign ca_n   = cos_a - (sin_a >>> ROT_SHIFT_A);
    assign sa_n   = sin_a + (ca_n >>> ROT_SHIFT_A);
    assign cab_a  = cos_ab - (sin_ab >>> ROT_SHIFT_A);
    assign sab_a  = sin_ab + (cab_a >>> ROT_SHIFT_A);
    assign cacb_a = cos_a_cos_b - (sin_a_cos_b >>> ROT_SHIFT_A);
    assign sacb_a = sin_a_cos_b + (cacb_a >>> ROT_SHIFT_A);
    assign cb_n   = cos_b - (sin_b >>> ROT_SHIFT_B);
    assign sb_n   = sin_b + (cb_n >>> ROT_SHIFT_B);
    assign cacb_n = cacb_a - (cab_a >>> ROT_SHIFT_B);
    assign cab_n  = cab_a + (cacb_n >>> ROT_SHIFT_B);
    assign sacb_n = sacb_a - (sab_a >>> ROT_SHIFT_B);
    assign sab_n  = sab_a + (sacb_n >>> ROT_SHIFT_B);
    // A full b revolution accumulates rounding drift; snap back to the start pose.
    assign wrap   = sin_b[15] && !sb_n[15];

    logic rot_trig;
    assign rot_trig = (h_count == H_TRIG) && (v_count == V_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rot_trig && !pause) state_nx = ROT;
            ROT:     if (step_cnt == 2'd0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            step_cnt <= 2'd0;
        end else begin
            state    <= state_nx;
            step_cnt <= (state == IDLE) ? speed : step_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || (state == ROT && wrap)) begin
            cos_a       <= INIT_A;
            sin_a       <= INIT_A;
            cos_b       <= INIT_ONE;
            sin_b       <= '0;
            sin_ab      <= '0;
            cos_ab      <= '0;
            sin_a_cos_b <= INIT_A;
            cos_a_cos_b <= INIT_A;
        end else if (state == ROT) begin
            cos_a       <= ca_n;
            sin_a       <= sa_n;
            cos_b       <= cb_n;
            sin_b       <= sb_n;
            sin_ab      <= sab_n;
            cos_ab      <= cab_n;
            sin_a_cos_b <= sacb_n;
            cos_a_cos_b <= cacb_n;
        end
    end

    logic signed [15:0] cam_x, cam_y, cam_zp;
    assign cam_x  = (sin_b + (sin_b >>> 2)) >>> 4;
    assign cam_y  = (sin_a_cos_b + (sin_a_cos_b >>> 2)) >>> 4;
    assign cam_zp = (cos_a_cos_b + (cos_a_cos_b >>> 2)) >>> 4;

    assign mq.light_x = sin_b >>> 2;
    assign mq.light_y = (sin_a_cos_b - cos_a) >>> 2;
    assign mq.light_z = (-cos_a_cos_b - sin_a) >>> 2;

    // Query slot and pixel-step timing.
    logic [PIX_LOG2:0] phase;
`ifdef DITHER_PHASE_EN
    always_comb begin
        phase = '0;
        phase[PIX_LOG2 -: 3] = {v_count[0] ^ frame, v_count[0], v_count[1] ^ frame};
    end
`else
    assign phase = '0;
`endif

    logic slot, ray_step, line_end, frame_end, busy, free;
    assign slot      = (h_count < H_ACT) && (h_count[PIX_LOG2:0] == phase);
    assign ray_step  = (h_count < H_ACT) && (&h_count[PIX_LOG2-1:0]) && !slot;
    assign line_end  = (h_count == H_LAST);
    assign frame_end = line_end && (v_count == V_LAST);

    logic signed [21:0] scan_cos, scan_sin, ray_x, ray_y, ray_z;
    logic signed [21:0] inc_cos, inc_sin, cb22, sb22, sab22, cab22, sacb22, cacb22;
    logic signed [21:0] x0, y0, z0;
    assign inc_cos = sx(cos_a >>> 2);
    assign inc_sin = sx(sin_a >>> 2);
    assign cb22    = sx(cos_b);
    assign sb22    = sx(sin_b);
    assign sab22   = sx(sin_ab);
    assign cab22   = sx(cos_ab);
    assign sacb22  = sx(sin_a_cos_b);
    assign cacb22  = sx(cos_a_cos_b);
    // Line start sits 40 pixel-steps left of centre, offset by the camera position.
    assign x0 = -((cb22 <<< 5) + (cb22 <<< 3)) - (sb22 <<< 6);
    assign y0 = scan_cos + ((sab22 <<< 5) + (sab22 <<< 3)) - (sacb22 <<< 6);
    assign z0 = scan_sin - ((cab22 <<< 5) + (cab22 <<< 3)) + (cacb22 <<< 6);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cos <= '0;
            scan_sin <= '0;
            ray_x    <= '0;
            ray_y    <= '0;
            ray_z    <= '0;
        end else if (frame_end) begin
            scan_cos <= -(inc_cos <<< 8) + (inc_cos <<< 4);
            scan_sin <= -(inc_sin <<< 8) + (inc_sin <<< 4);
        end else if (line_end) begin
            scan_cos <= scan_cos + inc_cos;
            scan_sin <= scan_sin + inc_sin;
            ray_x    <= x0;
            ray_y    <= y0;
            ray_z    <= z0;
        end else if (ray_step) begin
            ray_x <= ray_x + cb22;
            ray_y <= ray_y - sab22;
            ray_z <= ray_z + cab22;
        end
    end

    assign mq.dir_x    = ray_x[21:6];
    assign mq.dir_y    = ray_y[21:6];
    assign mq.dir_z    = ray_z[21:6];
    assign mq.origin_x = cam_x + {{6{ray_x[20]}}, ray_x[20:11]};
    assign mq.origin_y = cam_y + {{6{ray_y[20]}}, ray_y[20:11]};
    assign mq.origin_z = -cam_zp + {{6{ray_z[20]}}, ray_z[20:11]};

    // A done arriving in the slot cycle frees the marcher for that same slot.
    assign free           = !busy || mq.march_done;
    assign mq.march_start = rst_n && slot && free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            overrun     <= 1'b0;
            obj_visible <= 1'b0;
            obj_luma    <= '0;
        end else begin
            if (mq.march_start)    busy <= 1'b1;
            else if (mq.march_done) busy <= 1'b0;
            if (slot && !free)     overrun <= 1'b1;
            if (mq.march_done && busy) begin
                obj_visible <= mq.march_hit;
                obj_luma    <= {~mq.march_intensity[13], mq.march_intensity[12:14-LUMA_W]};
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{frame, mq.march_intensity[15:14], mq.march_intensity[13-LUMA_W:0],
                           ray_x[5:0], ray_y[5:0], ray_z[5:0]};
endmodule

// File: tb/tb_raymarch_view_core.sv
// Bench for raymarch_view_core: table-driven marcher results via a scoreboard,
// plus sequences for rotation model, pause, overrun and query phase.
module tb_raymarch_view_core;
    localparam int RA = 5;
    localparam int RB = 6;
    localparam int LW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [10:0] h_count = '0;
    logic [9:0]  v_count = '0;
    logic frame = 1'b0, pause = 1'b0;
    logic [1:0] speed = 2'd0;
    logic obj_visible;
    logic [LW-1:0] obj_luma;
    logic overrun;

    raymarch_view_core_if mif();

    raymarch_view_core #(
        .H_VISIBLE(640), .H_TOTAL(800), .V_TOTAL(525), .PIX_LOG2(3),
        .ROT_SHIFT_A(RA), .ROT_SHIFT_B(RB), .LUMA_W(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
        .frame(frame), .pause(pause), .speed(speed), .mq(mif),
        .obj_visible(obj_visible), .obj_luma(obj_luma), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int h, input int v);
        @(posedge clk);
        #1;
        h_count = 11'(h);
        v_count = 10'(v);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(700, 8);
    endtask

    typedef struct {
        logic          hit;
        logic [15:0]   inten;
        logic          vis;
        logic [LW-1:0] luma;
    } vec_t;

    vec_t tbl[6];
    vec_t cur;
    vec_t q[$];
    int   lat = 5;
    int   due = -1;
    int   chk_d = 0;
    int   n_start = 0;
    bit   spur = 1'b0;

    // Marcher model: answers each start after 'lat' cycles; scoreboard checks outputs.
    initial begin
        mif.march_done = 1'b0;
        mif.march_hit = 1'b0;
        mif.march_intensity = '0;
        forever begin
            @(negedge clk);
            if (chk_d == 1) begin
                if (q.size() == 0) begin
                    check("scoreboard_underflow", 16'(q.size()), 16'd1);
                end else begin
                    vec_t e;
                    e = q.pop_front();
                    check("obj_visible", 16'(obj_visible), 16'(e.vis));
                    check("obj_luma", 16'(obj_luma), 16'(e.luma));
                end
            end
            if (chk_d > 0) chk_d--;
            if (mif.march_start === 1'b1) begin
                q.push_back(cur);
                due = lat;
                n_start++;
            end
            @(posedge clk);
            #1;
            mif.march_done = 1'b0;
            mif.march_hit = 1'b0;
            mif.march_intensity = '0;
            if (due > 0) begin
                due--;
                if (due == 0 && q.size() > 0) begin
                    mif.march_done = 1'b1;
                    mif.march_hit = q[0].hit;
                    mif.march_intensity = q[0].inten;
                    due = -1;
                    chk_d = 2;
                end
            end else if (spur) begin
                mif.march_done = 1'b1;
                mif.march_hit = 1'b1;
                mif.march_intensity = 16'h3F00;
                spur = 1'b0;
            end
        end
    end

    logic signed [15:0] m_ca, m_sa, m_cb, m_sb, m_sab, m_cab, m_sacb, m_cacb;

    task automatic model_reset();
        m_ca = 16'sh2d3f; m_sa = 16'sh2d3f; m_cb = 16'sh4000; m_sb = 16'sh0;
        m_sab = 16'sh0; m_cab = 16'sh0; m_sacb = 16'sh2d3f; m_cacb = 16'sh2d3f;
    endtask

    task automatic model_step();
        logic signed [15:0] ca, sa, cab, sab, cacb, sacb, cb, sb;
        ca   = m_ca - (m_sa >>> RA);
        sa   = m_sa + (ca >>> RA);
        cab  = m_cab - (m_sab >>> RA);
        sab  = m_sab + (cab >>> RA);
        cacb = m_cacb - (m_sacb >>> RA);
        sacb = m_sacb + (cacb >>> RA);
        cb   = m_cb - (m_sb >>> RB);
        sb   = m_sb + (cb >>> RB);
        cacb = cacb - (cab >>> RB);
        cab  = cab + (cacb >>> RB);
        sacb = sacb - (sab >>> RB);
        sab  = sab + (sacb >>> RB);
        if (m_sb < 0 && sb >= 0) begin
            model_reset();
        end else begin
            m_ca = ca; m_sa = sa; m_cb = cb; m_sb = sb;
            m_sab = sab; m_cab = cab; m_sacb = sacb; m_cacb = cacb;
        end
    endtask

    task automatic check_orient(input string tag);
        check({tag, "_cos_a"}, dut.cos_a, m_ca);
        check({tag, "_sin_a"}, dut.sin_a, m_sa);
        check({tag, "_cos_b"}, dut.cos_b, m_cb);
        check({tag, "_sin_b"}, dut.sin_b, m_sb);
        check({tag, "_sin_ab"}, dut.sin_ab, m_sab);
        check({tag, "_cos_ab"}, dut.cos_ab, m_cab);
        check({tag, "_sin_a_cos_b"}, dut.sin_a_cos_b, m_sacb);
        check({tag, "_cos_a_cos_b"}, dut.cos_a_cos_b, m_cacb);
    endtask

    task automatic first_start(input logic f, output int hs);
        hs = -1;
        frame = f;
        for (int h = 0; h < 32; h++) begin
            cyc(h, 1);
            if (hs < 0 && mif.march_start === 1'b1) hs = h;
        end
        frame = 1'b0;
        idle(10);
    endtask

    initial begin
        int s0, hs0, hs1, e0, e1;
        logic signed [21:0] cb22, sb22, x0, x1;
        logic signed [9:0]  xs;
        logic signed [15:0] camx;

        tbl[0] = '{1'b1, 16'h0A00, 1'b1, 6'h2A};
        tbl[1] = '{1'b0, 16'h0000, 1'b0, 6'h20};
        tbl[2] = '{1'b1, 16'h3F00, 1'b1, 6'h1F};
        tbl[3] = '{1'b1, 16'hE000, 1'b1, 6'h00};
        tbl[4] = '{1'b1, 16'h2100, 1'b1, 6'h01};
        tbl[5] = '{1'b0, 16'h1FFF, 1'b0, 6'h3F};
        cur = tbl[0];

        // Reset mid-line; hold it across a query slot.
        #2 rst_n = 1'b0;
        cyc(0, 5);
        check("start_in_reset", 16'(mif.march_start), 16'd0);
        cyc(300, 5);
        rst_n = 1'b1;
        cyc(300, 5);
        check("rst_cos_a", dut.cos_a, 16'h2d3f);
        check("rst_cos_b", dut.cos_b, 16'h4000);
        check("rst_obj_luma", 16'(obj_luma), 16'h0);
        check("rst_obj_visible", 16'(obj_visible), 16'h0);
        check("rst_overrun", 16'(overrun), 16'h0);
        check("rst_start", 16'(mif.march_start), 16'h0);
        check("rst_light_x", mif.light_x, 16'h0000);
        check("rst_light_y", mif.light_y, 16'h0000);
        check("rst_light_z", mif.light_z, 16'hE960);
        check("rst_origin_y", mif.origin_y, 16'h0388);
        check("rst_origin_z", mif.origin_z, 16'hFC78);
        check("rst_dir_x", mif.dir_x, 16'h0000);
        idle(4);

        // Table: latency 5, one query per 16-clock period.
        lat = 5;
        for (int i = 0; i < 6; i++) begin
            cur = tbl[i];
            for (int h = 0; h < 16; h++) cyc(h, 8);
        end
        idle(10);
        check("overrun_lat5", 16'(overrun), 16'h0);

        // Stray done while idle must not touch the outputs.
        spur = 1'b1;
        idle(4);
        check("spur_visible", 16'(obj_visible), 16'(tbl[5].vis));
        check("spur_luma", 16'(obj_luma), 16'(tbl[5].luma));

        // Done coinciding with the next slot: start still issued, no overrun.
        lat = 16;
        cur = tbl[2];
        s0 = n_start;
        for (int h = 0; h <= 40; h++) begin
            cyc(h, 8);
            if (h == 16) check("coincide_start", 16'(mif.march_start), 16'h1);
        end
        idle(24);
        check("coincide_starts", 16'(n_start - s0), 16'd3);
        check("coincide_overrun", 16'(overrun), 16'h0);

        // Latency 20 overruns the 16-clock period.
        lat = 20;
        cur = tbl[4];
        s0 = n_start;
        for (int h = 0; h < 48; h++) begin
            cyc(h, 8);
            if (h == 15) check("ovr_before", 16'(overrun), 16'h0);
            if (h == 16) check("ovr_skip_start", 16'(mif.march_start), 16'h0);
            if (h == 17) check("ovr_set", 16'(overrun), 16'h1);
            if (h == 32) check("ovr_next_start", 16'(mif.march_start), 16'h1);
        end
        idle(30);
        check("ovr_starts", 16'(n_start - s0), 16'd2);
        lat = 5;
        cur = tbl[0];

        // Rotation across frame ends against the golden model (includes a b-wrap).
        model_reset();
        for (int f = 0; f < 120; f++) begin
            speed = (f < 3) ? 2'(f) : 2'd3;
            for (int h = 780; h < 800; h++) cyc(h, 524);
            for (int s = 0; s <= int'(speed); s++) model_step();
            check_orient("rot");
        end

        // Paused frames leave orientation alone.
        pause = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int h = 780; h < 800; h++) cyc(h, 524);
            check_orient("pause");
        end

        // Ray accumulators still reload per line while paused.
        cb22 = {{6{m_cb[15]}}, m_cb};
        sb22 = {{6{m_sb[15]}}, m_sb};
        x0 = -(cb22 * 22'sd40) - (sb22 * 22'sd64);
        x1 = x0 + cb22;
        xs = x0[20:11];
        camx = (m_sb + (m_sb >>> 2)) >>> 4;
        cyc(799, 99);
        cyc(0, 100);
        check("line_dir_x", mif.dir_x, x0[21:6]);
        check("line_origin_x", mif.origin_x, camx + {{6{xs[9]}}, xs});
        for (int h = 1; h <= 8; h++) cyc(h, 100);
        check("step_dir_x", mif.dir_x, x1[21:6]);
        idle(12);
        pause = 1'b0;

        // Query phase per line/frame.
`ifdef DITHER_PHASE_EN
        e0 = 12;
        e1 = 6;
`else
        e0 = 0;
        e1 = 0;
`endif
        first_start(1'b0, hs0);
        first_start(1'b1, hs1);
        check("phase_frame0", 16'(hs0), 16'(e0));
        check("phase_frame1", 16'(hs1), 16'(e1));

        check("overrun_sticky", 16'(overrun), 16'h1);
        check("scoreboard_drain", 16'(q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
